// File: rtl/alu_dispatch_if.sv
// alu_dispatch_if: bundles the upstream instruction handshake, the downstream
// ALU issue handshake, the flush strobe and the event counters of alu_dispatch.
//   slave  modport: the dispatch block (takes instructions, drives the issue).
//   master modport: the surrounding pipeline (drives instructions, consumes).
// Upstream:   in_valid, in_ready, instr[31:0], pc, rs1_val, rs2_val, flush
// Downstream: out_valid, out_ready, alu_a, alu_b, alu_op[3:0], rd[4:0], illegal
// Status:     issue_cnt[31:0], illegal_cnt[31:0]
interface alu_dispatch_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [4:0]      rd;
    logic            illegal;
    logic [31:0]     issue_cnt;
    logic [31:0]     illegal_cnt;

    modport slave (
        input  in_valid, instr, pc, rs1_val, rs2_val, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, rd, illegal,
               issue_cnt, illegal_cnt
    );

    modport master (
        output in_valid, instr, pc, rs1_val, rs2_val, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, illegal,
               issue_cnt, illegal_cnt
    );
endinterface

// File: rtl/alu_dispatch.sv
// alu_dispatch: decodes RV32I register/immediate ALU instructions (OP, OP-IMM,
// LUI, AUIPC) into registered ALU operands and opcode, behind a one-entry
// valid/ready skid-free register stage.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset, clears control, data and counters
//   bus   : alu_dispatch_if.slave (instruction in, ALU issue out, flush,
//           issue/illegal counters)
// alu_op encoding: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu,
// 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1001 pass-b.
module alu_dispatch #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_dispatch_if.slave  bus
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic            ill;
    } dec_t;

    // Undecodable words default to a zeroed add with the illegal flag set.
    function automatic dec_t decode(input logic [31:0]     ins,
                                    input logic [XLEN-1:0] pc_v,
                                    input logic [XLEN-1:0] rs1_v,
                                    input logic [XLEN-1:0] rs2_v);
        dec_t                   d;
        logic [6:0]             opcode;
        logic [6:0]             funct7;
        logic [2:0]             funct3;
        logic signed [XLEN-1:0] imm_i;
        logic [XLEN-1:0]        imm_u;
        opcode = ins[6:0];
        funct7 = ins[31:25];
        funct3 = ins[14:12];
        imm_i  = {{(XLEN-12){ins[31]}}, ins[31:20]};
        imm_u  = {{(XLEN-32){1'b0}}, ins[31:12], 12'b0};
        d      = '{a: '0, b: '0, op: 4'b0000, ill: 1'b1};
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_ZERO ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    d = '{a: rs1_v, b: rs2_v, op: {ins[30], funct3}, ill: 1'b0};
                end
            end
            OPC_IMM: begin
                // Only the shift forms qualify funct7; bit 30 of other
                // immediates is plain immediate data.
                if ((funct3 == 3'b001 && funct7 == F7_ZERO) ||
                    (funct3 == 3'b101 && (funct7 == F7_ZERO || funct7 == F7_ALT)) ||
                    (funct3 != 3'b001 && funct3 != 3'b101)) begin
                    d = '{a: rs1_v, b: imm_i,
                          op: {(funct3 == 3'b101) ? ins[30] : 1'b0, funct3},
                          ill: 1'b0};
                end
            end
            OPC_LUI:   d = '{a: '0,   b: imm_u, op: 4'b1001, ill: 1'b0};
            OPC_AUIPC: d = '{a: pc_v, b: imm_u, op: 4'b0000, ill: 1'b0};
            default:   d = '{a: '0, b: '0, op: 4'b0000, ill: 1'b1};
        endcase
        return d;
    endfunction

    logic [0:0]      state_p1;
    logic            vld_p1;
    logic [XLEN-1:0] alu_a_p1;
    logic [XLEN-1:0] alu_b_p1;
    logic [3:0]      alu_op_p1;
    logic [4:0]      rd_p1;
    logic            ill_p1;
    logic [31:0]     issue_cnt_q;
    logic [31:0]     illegal_cnt_q;

    logic            ready;
    logic            accept;
    logic            consume;
    dec_t            dec_p0;

    // Stage p0: combinational decode and handshake
    assign vld_p1  = (state_p1 == FULL);
    assign ready   = !vld_p1 || bus.out_ready;
    assign accept  = bus.in_valid && ready && !bus.flush;
    assign consume = vld_p1 && bus.out_ready;
    assign dec_p0  = decode(bus.instr, bus.pc, bus.rs1_val, bus.rs2_val);

    // Stage p1: registered issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1      <= EMPTY;
            alu_a_p1      <= '0;
            alu_b_p1      <= '0;
            alu_op_p1     <= 4'b0000;
            rd_p1         <= 5'd0;
            ill_p1        <= 1'b0;
            issue_cnt_q   <= 32'd0;
            illegal_cnt_q <= 32'd0;
        end else begin
            if (bus.flush) begin
                state_p1 <= EMPTY;
            end else if (accept) begin
                state_p1 <= FULL;
            end else if (consume) begin
                state_p1 <= EMPTY;
            end

            if (accept) begin
                alu_a_p1  <= dec_p0.a;
                alu_b_p1  <= dec_p0.b;
                alu_op_p1 <= dec_p0.op;
                rd_p1     <= bus.instr[11:7];
                ill_p1    <= dec_p0.ill;
            end

            // A flushed issue is not counted even if downstream took it.
            if (consume && !bus.flush) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
                if (ill_p1) begin
                    illegal_cnt_q <= illegal_cnt_q + 32'd1;
                end
            end
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = vld_p1;
    assign bus.alu_a       = alu_a_p1;
    assign bus.alu_b       = alu_b_p1;
    assign bus.alu_op      = alu_op_p1;
    assign bus.rd          = rd_p1;
    assign bus.illegal     = ill_p1;
    assign bus.issue_cnt   = issue_cnt_q;
    assign bus.illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_dispatch_if #(.XLEN(32)) bus ();

    alu_dispatch #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model state for the randomized run
    logic        m_valid;
    logic [31:0] m_a, m_b, m_icnt, m_lcnt;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    logic        m_ill;

    // Mnemonic-level decode: each recognised instruction picks its ALU function.
    function automatic void ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       output logic [31:0] a, output logic [31:0] b,
                                       output logic [3:0] op, output logic ill);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] imm_i, imm_u;
        f7 = ins[31:25];
        f3 = ins[14:12];
        imm_i = 32'($signed(ins[31:20]));
        imm_u = ins & 32'hFFFF_F000;
        a = 0; b = 0; op = 0; ill = 1;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin op = {1'b0, f3}; ill = 0; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin op = 4'h8; ill = 0; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin op = 4'hD; ill = 0; end
                if (!ill) begin a = r1; b = r2; end
            end
            7'h13: begin
                if (f3 == 3'd1) ill = (f7 != 7'h00);
                else if (f3 == 3'd5) ill = !(f7 == 7'h00 || f7 == 7'h20);
                else ill = 0;
                if (!ill) begin
                    a = r1; b = imm_i;
                    op = (f3 == 3'd5 && f7 == 7'h20) ? 4'hD : {1'b0, f3};
                end
            end
            7'h37: begin b = imm_u; op = 4'h9; ill = 0; end
            7'h17: begin a = pcv; b = imm_u; op = 4'h0; ill = 0; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        int          k;
        r = $urandom();
        k = $urandom_range(0, 9);
        case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom());
        endcase
        if (k <= 2) begin r[6:0] = 7'h33; r[31:25] = f7; end
        else if (k <= 5) begin r[6:0] = 7'h13; r[31:25] = f7; end
        else if (k == 6) r[6:0] = 7'h37;
        else if (k == 7) r[6:0] = 7'h17;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 0; bus.instr = 0; bus.pc = 0; bus.rs1_val = 0;
        bus.rs2_val = 0; bus.flush = 0; bus.out_ready = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        drive_idle();
        #2 rst_n = 0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.alu_a !== 32'd0) begin errors++; $display("FAIL rst_alu_a: got %h want 0", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd0) begin errors++; $display("FAIL rst_alu_b: got %h want 0", bus.alu_b); end
        checks++; if (bus.alu_op !== 4'd0) begin errors++; $display("FAIL rst_alu_op: got %b want 0", bus.alu_op); end
        checks++; if (bus.rd !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d want 0", bus.rd); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b want 0", bus.illegal); end
        checks++; if (bus.issue_cnt !== 32'd0) begin errors++; $display("FAIL rst_issue_cnt: got %0d want 0", bus.issue_cnt); end
        checks++; if (bus.illegal_cnt !== 32'd0) begin errors++; $display("FAIL rst_illegal_cnt: got %0d want 0", bus.illegal_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        do_reset();
    endtask

    task automatic test_sub();
        do_reset();
        bus.instr = 32'h402081B3; bus.rs1_val = 10; bus.rs2_val = 3;
        bus.in_valid = 1; bus.out_ready = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sub_in_ready: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sub_out_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.alu_op !== 4'b1000) begin errors++; $display("FAIL sub_op: got %b want 1000", bus.alu_op); end
        checks++; if (bus.alu_a !== 32'd10) begin errors++; $display("FAIL sub_a: got %0d want 10", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'd3) begin errors++; $display("FAIL sub_b: got %0d want 3", bus.alu_b); end
        checks++; if (bus.rd !== 5'd3) begin errors++; $display("FAIL sub_rd: got %0d want 3", bus.rd); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL sub_illegal: got %b want 0", bus.illegal); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain: got %b want 0", bus.out_valid); end
        checks++; if (bus.issue_cnt !== 32'd1) begin errors++; $display("FAIL sub_issue_cnt: got %0d want 1", bus.issue_cnt); end
    endtask

    // Back-to-back immediates: one issue per cycle with out_ready held high.
    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1; bus.in_valid = 1; bus.rs1_val = 32'h8000_0001;
        bus.instr = 32'h40435293;   // srai x5,x6,4
        tick();
        bus.instr = 32'h40030293;   // addi x5,x6,0x400 (imm bit 11 clear)
        checks++; if (bus.alu_op !== 4'b1101) begin errors++; $display("FAIL srai_op: got %b want 1101", bus.alu_op); end
        checks++; if (bus.alu_b !== 32'h0000_0404) begin errors++; $display("FAIL srai_b: got %h want 00000404", bus.alu_b); end
        checks++; if (bus.rd !== 5'd5) begin errors++; $display("FAIL srai_rd: got %0d want 5", bus.rd); end
        tick();
        bus.instr = 32'hC0030293;   // addi x5,x6,-1024 (bit 30 set)
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.alu_op !== 4'b0000) begin errors++; $display("FAIL addi_op: got %b want 0000", bus.alu_op); end
        checks++; if (bus.alu_b !== 32'h0000_0400) begin errors++; $display("FAIL addi_b: got %h want 00000400", bus.alu_b); end
        checks++; if (bus.alu_a !== 32'h8000_0001) begin errors++; $display("FAIL addi_a: got %h want 80000001", bus.alu_a); end
        tick();
        bus.in_valid = 0;
        checks++; if (bus.alu_op !== 4'b0000) begin errors++; $display("FAIL addi_neg_op: got %b want 0000", bus.alu_op); end
        checks++; if (bus.alu_b !== 32'hFFFF_FC00) begin errors++; $display("FAIL addi_neg_b: got %h want fffffc00", bus.alu_b); end
        tick();
        checks++; if (bus.issue_cnt !== 32'd3) begin errors++; $display("FAIL b2b_issue_cnt: got %0d want 3", bus.issue_cnt); end
    endtask

    task automatic test_upper();
        do_reset();
        bus.out_ready = 1; bus.in_valid = 1; bus.rs1_val = 32'hDEAD_BEEF; bus.pc = 32'h100;
        bus.instr = 32'h123450B7;   // lui x1,0x12345
        tick();
        bus.instr = 32'h12345117;   // auipc x2,0x12345
        checks++; if (bus.alu_op !== 4'b1001) begin errors++; $display("FAIL lui_op: got %b want 1001", bus.alu_op); end
        checks++; if (bus.alu_a !== 32'd0) begin errors++; $display("FAIL lui_a: got %h want 0", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'h1234_5000) begin errors++; $display("FAIL lui_b: got %h want 12345000", bus.alu_b); end
        checks++; if (bus.rd !== 5'd1) begin errors++; $display("FAIL lui_rd: got %0d want 1", bus.rd); end
        tick();
        bus.in_valid = 0;
        checks++; if (bus.alu_op !== 4'b0000) begin errors++; $display("FAIL auipc_op: got %b want 0000", bus.alu_op); end
        checks++; if (bus.alu_a !== 32'h100) begin errors++; $display("FAIL auipc_a: got %h want 100", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'h1234_5000) begin errors++; $display("FAIL auipc_b: got %h want 12345000", bus.alu_b); end
        checks++; if (bus.rd !== 5'd2) begin errors++; $display("FAIL auipc_rd: got %0d want 2", bus.rd); end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        bus.in_valid = 1; bus.out_ready = 0;
        bus.instr = 32'h002081B3; bus.rs1_val = 5; bus.rs2_val = 6;   // add x3,x1,x2
        tick();
        bus.instr = 32'h0020C233; bus.rs1_val = 7; bus.rs2_val = 1;   // xor x4,x1,x2
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.out_valid); end
            checks++; if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.rd} !== {4'b0000, 32'd5, 32'd6, 5'd3}) begin
                errors++; $display("FAIL stall_hold[%0d]: got op=%b a=%0d b=%0d rd=%0d want op=0000 a=5 b=6 rd=3", i, bus.alu_op, bus.alu_a, bus.alu_b, bus.rd); end
            tick();
        end
        bus.out_ready = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        checks++; if ({bus.out_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.rd} !== {1'b1, 4'b0100, 32'd7, 32'd1, 5'd4}) begin
            errors++; $display("FAIL release_next: got v=%b op=%b a=%0d b=%0d rd=%0d want v=1 op=0100 a=7 b=1 rd=4", bus.out_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.rd); end
        checks++; if (bus.issue_cnt !== 32'd1) begin errors++; $display("FAIL release_issue_cnt: got %0d want 1", bus.issue_cnt); end
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        bus.instr = 32'h0000007F; bus.rs1_val = 32'h55; bus.rs2_val = 32'hAA;
        bus.in_valid = 1; bus.out_ready = 1;
        tick();
        bus.in_valid = 0;
        checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", bus.illegal); end
        checks++; if ({bus.alu_a, bus.alu_b, bus.alu_op} !== {32'd0, 32'd0, 4'd0}) begin
            errors++; $display("FAIL ill_zero: got a=%h b=%h op=%b want zeros", bus.alu_a, bus.alu_b, bus.alu_op); end
        tick();
        checks++; if (bus.issue_cnt !== 32'd1) begin errors++; $display("FAIL ill_issue_cnt: got %0d want 1", bus.issue_cnt); end
        checks++; if (bus.illegal_cnt !== 32'd1) begin errors++; $display("FAIL ill_illegal_cnt: got %0d want 1", bus.illegal_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.instr = 32'h402081B3; bus.rs1_val = 10; bus.rs2_val = 3;
        bus.in_valid = 1; bus.out_ready = 0;
        tick();
        bus.flush = 1; bus.out_ready = 1; bus.instr = 32'h123450B7;
        tick();
        bus.flush = 0; bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
        checks++; if ({bus.alu_op, bus.alu_b} !== {4'b1000, 32'd3}) begin
            errors++; $display("FAIL flush_no_capture: got op=%b b=%h want op=1000 b=3", bus.alu_op, bus.alu_b); end
        checks++; if ({bus.issue_cnt, bus.illegal_cnt} !== 64'd0) begin
            errors++; $display("FAIL flush_cnt: got %0d/%0d want 0/0", bus.issue_cnt, bus.illegal_cnt); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stay_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.instr = 32'h402081B3; bus.rs1_val = 10; bus.rs2_val = 3;
        bus.in_valid = 1; bus.out_ready = 0;
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL areset_full: got %b want 1", bus.out_valid); end
        #2 rst_n = 0;
        #1;
        checks++; if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op, bus.rd, bus.illegal} !== '0) begin
            errors++; $display("FAIL areset_clear: got v=%b a=%h b=%h op=%b rd=%0d ill=%b want zeros", bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op, bus.rd, bus.illegal); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready: got %b want 1", bus.in_ready); end
        tick();
        drive_idle();
        rst_n = 1;
    endtask

    task automatic test_random();
        logic        rdy, acc, cons;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        ill;
        do_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_ill = 0; m_icnt = 0; m_lcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.instr     = rand_instr();
            bus.pc        = $urandom();
            bus.rs1_val   = $urandom();
            bus.rs2_val   = $urandom();
            #1;
            rdy  = !m_valid || bus.out_ready;
            acc  = bus.in_valid && rdy && !bus.flush;
            cons = m_valid && bus.out_ready;
            checks++; if (bus.in_ready !== rdy) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, bus.in_ready, rdy); end
            if (cons && !bus.flush) begin
                m_icnt = m_icnt + 1;
                if (m_ill) m_lcnt = m_lcnt + 1;
            end
            if (acc) begin
                ref_decode(bus.instr, bus.pc, bus.rs1_val, bus.rs2_val, a, b, op, ill);
                m_a = a; m_b = b; m_op = op; m_ill = ill; m_rd = bus.instr[11:7];
            end
            if (bus.flush) m_valid = 0;
            else if (acc) m_valid = 1;
            else if (cons) m_valid = 0;
            tick();
            checks++; if ({bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op, bus.rd, bus.illegal} !== {m_valid, m_a, m_b, m_op, m_rd, m_ill}) begin
                errors++; $display("FAIL rnd_issue[%0d]: got v=%b a=%h b=%h op=%b rd=%0d ill=%b want v=%b a=%h b=%h op=%b rd=%0d ill=%b",
                    i, bus.out_valid, bus.alu_a, bus.alu_b, bus.alu_op, bus.rd, bus.illegal, m_valid, m_a, m_b, m_op, m_rd, m_ill); end
            checks++; if ({bus.issue_cnt, bus.illegal_cnt} !== {m_icnt, m_lcnt}) begin
                errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bus.issue_cnt, bus.illegal_cnt, m_icnt, m_lcnt); end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_upper();
        test_stall();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end
endmodule
